better_neighbors_in_my_cluster: RTL and testbench



---
 rtl/better_neighbors_in_my_cluster_if.sv | 24 ++
 rtl/better_neighbors_in_my_cluster.sv | 197 +++++++++++++++++++
 tb/tb_better_neighbors_in_my_cluster.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/better_neighbors_in_my_cluster_if.sv
// Shared-memory port of the better-neighbors stage: byte address, write strobe,
// write data and registered read data (one cycle after the address is presented).
interface better_neighbors_in_my_cluster_if #(
  parameter int WORD_WIDTH = 16
);
  logic [WORD_WIDTH-1:0] mem_addr;
  logic                  mem_wr_en;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic [WORD_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wr_en,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/better_neighbors_in_my_cluster.sv
// Scans the neighbor table, records in-cluster neighbors that beat my_best,
// tracks the best in-cluster neighbor and writes the better list and its count back.
module better_neighbors_in_my_cluster #(
  parameter int WORD_WIDTH    = 16,
  parameter int MAX_NEIGHBORS = 64,
  parameter int MAX_BETTER    = 16
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  start,
  better_neighbors_in_my_cluster_if.master mem,
  input  logic [WORD_WIDTH-1:0] my_cluster_id,
  input  logic [WORD_WIDTH-1:0] my_best,
  output logic [WORD_WIDTH-1:0] best_hop,
  output logic [WORD_WIDTH-1:0] best_value,
  output logic [WORD_WIDTH-1:0] best_neighbor_id,
  output logic [WORD_WIDTH-1:0] next_sinks,
  output logic                  done
);
  localparam int IDX_W = $clog2(MAX_NEIGHBORS) + 1;
  localparam int K_W   = $clog2(MAX_BETTER) + 1;
  localparam logic [WORD_WIDTH-1:0] ADDR_ID     = WORD_WIDTH'(16'h0048);
  localparam logic [WORD_WIDTH-1:0] ADDR_CLUS   = WORD_WIDTH'(16'h00C8);
  localparam logic [WORD_WIDTH-1:0] ADDR_Q      = WORD_WIDTH'(16'h01C8);
  localparam logic [WORD_WIDTH-1:0] ADDR_SINK   = WORD_WIDTH'(16'h0248);
  localparam logic [WORD_WIDTH-1:0] ADDR_BETTER = WORD_WIDTH'(16'h0668);
  localparam logic [WORD_WIDTH-1:0] ADDR_CNT    = WORD_WIDTH'(16'h068A);
  localparam logic [WORD_WIDTH-1:0] ADDR_BCNT   = WORD_WIDTH'(16'h068C);

  typedef enum logic [3:0] {
    IDLE, RD_CNT, RD_CLUS, RD_Q, RD_ID, EVAL, WR_BETTER, NEXT, RD_SINK, WR_CNT, DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  phase_q, phase_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      n_q, n_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [WORD_WIDTH-1:0] best_hop_q, best_hop_d;
  logic [WORD_WIDTH-1:0] best_value_q, best_value_d;
  logic [WORD_WIDTH-1:0] best_id_q, best_id_d;
  logic [WORD_WIDTH-1:0] next_sinks_q, next_sinks_d;
  logic [WORD_WIDTH-1:0] q_q, q_d;
  logic [WORD_WIDTH-1:0] id_q, id_d;
  logic                  done_q, done_d;

  logic [IDX_W-1:0] n_clamp;
  logic [IDX_W-1:0] idx_next;

  assign n_clamp  = (mem.mem_rdata > WORD_WIDTH'(MAX_NEIGHBORS)) ?
                    IDX_W'(MAX_NEIGHBORS) : mem.mem_rdata[IDX_W-1:0];
  assign idx_next = idx_q + IDX_W'(1);

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      phase_q      <= 1'b0;
      idx_q        <= '0;
      n_q          <= '0;
      k_q          <= '0;
      best_hop_q   <= '1;
      best_value_q <= '1;
      best_id_q    <= '1;
      next_sinks_q <= '0;
      q_q          <= '0;
      id_q         <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      n_q          <= n_d;
      k_q          <= k_d;
      best_hop_q   <= best_hop_d;
      best_value_q <= best_value_d;
      best_id_q    <= best_id_d;
      next_sinks_q <= next_sinks_d;
      q_q          <= q_d;
      id_q         <= id_d;
      done_q       <= done_d;
    end
  end

  // Every read state spends two cycles: phase 0 presents the address, phase 1 samples the data.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    idx_d        = idx_q;
    n_d          = n_q;
    k_d          = k_q;
    best_hop_d   = best_hop_q;
    best_value_d = best_value_q;
    best_id_d    = best_id_q;
    next_sinks_d = next_sinks_q;
    q_d          = q_q;
    id_d         = id_q;
    done_d       = done_q;
    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          state_d = RD_CNT;
          phase_d = 1'b0;
        end
      end
      RD_CNT: begin
        phase_d = !phase_q;
        if (phase_q) begin
          n_d     = n_clamp;
          idx_d   = '0;
          state_d = (n_clamp == '0) ? WR_CNT : RD_CLUS;
        end
      end
      RD_CLUS: begin
        phase_d = !phase_q;
        if (phase_q) state_d = (mem.mem_rdata == my_cluster_id) ? RD_Q : NEXT;
      end
      RD_Q: begin
        phase_d = !phase_q;
        if (phase_q) begin
          q_d     = mem.mem_rdata;
          state_d = RD_ID;
        end
      end
      RD_ID: begin
        phase_d = !phase_q;
        if (phase_q) begin
          id_d    = mem.mem_rdata;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (q_q < best_value_q) begin
          best_hop_d   = WORD_WIDTH'(idx_q);
          best_value_d = q_q;
          best_id_d    = id_q;
        end
        state_d = (q_q < my_best && k_q < K_W'(MAX_BETTER)) ? WR_BETTER : NEXT;
      end
      WR_BETTER: begin
        k_d     = k_q + K_W'(1);
        state_d = NEXT;
      end
      NEXT: begin
        if (idx_next < n_q) begin
          idx_d   = idx_next;
          state_d = RD_CLUS;
        end else begin
          state_d = (best_hop_q != '1) ? RD_SINK : WR_CNT;
        end
      end
      RD_SINK: begin
        phase_d = !phase_q;
        if (phase_q) begin
          next_sinks_d = mem.mem_rdata;
          state_d      = WR_CNT;
        end
      end
      WR_CNT: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Memory address and write strobe follow directly from the registered state.
  always_comb begin
    mem.mem_addr  = '0;
    mem.mem_wr_en = 1'b0;
    mem.mem_wdata = '0;
    case (state_q)
      RD_CNT:  mem.mem_addr = ADDR_CNT;
      RD_CLUS: mem.mem_addr = ADDR_CLUS + WORD_WIDTH'({idx_q, 1'b0});
      RD_Q:    mem.mem_addr = ADDR_Q + WORD_WIDTH'({idx_q, 1'b0});
      RD_ID:   mem.mem_addr = ADDR_ID + WORD_WIDTH'({idx_q, 1'b0});
      RD_SINK: mem.mem_addr = ADDR_SINK + {best_hop_q[WORD_WIDTH-5:0], 4'b0000};
      WR_BETTER: begin
        mem.mem_addr  = ADDR_BETTER + WORD_WIDTH'({k_q, 1'b0});
        mem.mem_wr_en = 1'b1;
        mem.mem_wdata = id_q;
      end
      WR_CNT: begin
        mem.mem_addr  = ADDR_BCNT;
        mem.mem_wr_en = 1'b1;
        mem.mem_wdata = WORD_WIDTH'(k_q);
      end
      default: ;
    endcase
  end

  assign best_hop         = best_hop_q;
  assign best_value       = best_value_q;
  assign best_neighbor_id = best_id_q;
  assign next_sinks       = next_sinks_q;
  assign done             = done_q;
endmodule

// File: tb/tb_better_neighbors_in_my_cluster.sv
// Randomized and directed bench for better_neighbors_in_my_cluster: a queue of
// expected memory writes and final results is popped by an independent monitor.
module tb_better_neighbors_in_my_cluster;
  logic        clock = 1'b0;
  logic        nrst  = 1'b0;
  logic        start = 1'b0;
  logic [15:0] myCluster = '0;
  logic [15:0] myBest    = '0;
  logic [15:0] bestHop, bestValue, bestId, nextSinks;
  logic        done;

  int compared   = 0;
  int mismatched = 0;

  typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
  typedef struct { logic [15:0] hop; logic [15:0] val; logic [15:0] id; logic [15:0] sink; } fin_t;
  wr_t  expWr[$];
  fin_t expFin[$];

  logic [15:0] mem [0:1023];

  better_neighbors_in_my_cluster_if bus ();

  better_neighbors_in_my_cluster dut (
    .clock            (clock),
    .nrst             (nrst),
    .start            (start),
    .mem              (bus),
    .my_cluster_id    (myCluster),
    .my_best          (myBest),
    .best_hop         (bestHop),
    .best_value       (bestValue),
    .best_neighbor_id (bestId),
    .next_sinks       (nextSinks),
    .done             (done)
  );

  always #5 clock = ~clock;

  // Memory returns the word addressed during the previous cycle.
  always @(posedge clock) bus.mem_rdata <= mem[bus.mem_addr[10:1]];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe and the rising edge of done consume one expectation.
  initial begin
    logic prevDone;
    prevDone = 1'b0;
    forever begin
      @(negedge clock);
      if (nrst) begin
        if (bus.mem_wr_en) begin
          if (expWr.size() == 0) begin
            checkOutput("unexpected_write_addr", bus.mem_addr, 16'hDEAD);
          end else begin
            wr_t w;
            w = expWr.pop_front();
            checkOutput("write_addr", bus.mem_addr, w.addr);
            checkOutput("write_data", bus.mem_wdata, w.data);
          end
        end else if (bus.mem_wdata !== 16'h0) begin
          checkOutput("idle_wdata", bus.mem_wdata, 16'h0);
        end
        if (done && !prevDone) begin
          if (expFin.size() == 0) begin
            checkOutput("unexpected_done", {15'h0, done}, 16'h0);
          end else begin
            fin_t f;
            f = expFin.pop_front();
            checkOutput("best_hop", bestHop, f.hop);
            checkOutput("best_value", bestValue, f.val);
            checkOutput("best_neighbor_id", bestId, f.id);
            checkOutput("next_sinks", nextSinks, f.sink);
          end
        end
      end
      prevDone = done;
    end
  end

  task automatic checkResetState();
    checkOutput("rst_done", {15'h0, done}, 16'h0);
    checkOutput("rst_wr_en", {15'h0, bus.mem_wr_en}, 16'h0);
    checkOutput("rst_wdata", bus.mem_wdata, 16'h0);
    checkOutput("rst_addr", bus.mem_addr, 16'h0);
    checkOutput("rst_best_hop", bestHop, 16'hFFFF);
    checkOutput("rst_best_value", bestValue, 16'hFFFF);
    checkOutput("rst_best_id", bestId, 16'hFFFF);
    checkOutput("rst_next_sinks", nextSinks, 16'h0);
  endtask

  task automatic doReset();
    @(posedge clock); #1;
    start = 1'b0;
    nrst  = 1'b0;
    #1 checkResetState();
    repeat (2) @(posedge clock);
    #1 nrst = 1'b1;
  endtask

  task automatic fillBackground();
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
  endtask

  task automatic setNeighbor(input int i, input logic [15:0] id, input logic [15:0] clus,
                             input logic [15:0] q, input logic [15:0] sink);
    mem[(16'h48 + 2*i) >> 1]  = id;
    mem[(16'hC8 + 2*i) >> 1]  = clus;
    mem[(16'h1C8 + 2*i) >> 1] = q;
    mem[(16'h248 + 16*i) >> 1] = sink;
  endtask

  task automatic setCount(input logic [15:0] cnt);
    mem[16'h68A >> 1] = cnt;
  endtask

  // Reference: walk the table as the stage is meant to, producing the write list and final outputs.
  task automatic buildExpectations();
    int n, k, bi;
    logic [15:0] bv, bid;
    fin_t f;
    n  = int'(mem[16'h68A >> 1]);
    if (n > 64) n = 64;
    k  = 0;
    bi = -1;
    bv = 16'hFFFF;
    bid = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      logic [15:0] clus, q, id;
      clus = mem[(16'hC8 + 2*i) >> 1];
      q    = mem[(16'h1C8 + 2*i) >> 1];
      id   = mem[(16'h48 + 2*i) >> 1];
      if (clus == myCluster) begin
        if (q < bv) begin
          bi = i; bv = q; bid = id;
        end
        if (q < myBest && k < 16) begin
          expWr.push_back('{addr: 16'(16'h668 + 2*k), data: id});
          k++;
        end
      end
    end
    expWr.push_back('{addr: 16'h68C, data: 16'(k)});
    if (bi >= 0) begin
      f.hop  = 16'(bi);
      f.val  = bv;
      f.id   = bid;
      f.sink = mem[(16'h248 + 16*bi) >> 1];
    end else begin
      f.hop = 16'hFFFF; f.val = 16'hFFFF; f.id = 16'hFFFF; f.sink = 16'h0;
    end
    expFin.push_back(f);
  endtask

  // abortAfter > 0 pulls reset mid-scan after that many cycles and drops pending expectations.
  task automatic applyStimulus(input string caseName, input int abortAfter);
    int cycles;
    doReset();
    buildExpectations();
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    checkOutput({caseName, "_first_addr"}, bus.mem_addr, 16'h068A);
    if (abortAfter > 0) begin
      repeat (abortAfter) @(posedge clock);
      #1 nrst = 1'b0;
      #1 checkResetState();
      expWr.delete();
      expFin.delete();
      return;
    end
    cycles = 0;
    while (!done && cycles < 3000) begin
      @(posedge clock); #1;
      cycles++;
    end
    if (!done) begin
      checkOutput({caseName, "_timeout"}, 16'h0, 16'h1);
      expWr.delete();
      expFin.delete();
      return;
    end
    repeat (3) @(posedge clock);
    #1;
    start = 1'b0;
    checkOutput({caseName, "_done_held"}, {15'h0, done}, 16'h1);
    checkOutput({caseName, "_writes_left"}, 16'(expWr.size()), 16'h0);
    checkOutput({caseName, "_final_left"}, 16'(expFin.size()), 16'h0);
  endtask

  initial begin
    $display("[TB] starting");

    fillBackground();
    setCount(16'd3);
    setNeighbor(0, 16'd5, 16'd1, 16'd4, 16'h0A11);
    setNeighbor(1, 16'd6, 16'd2, 16'd1, 16'h0A22);
    setNeighbor(2, 16'd7, 16'd1, 16'd9, 16'h0A33);
    myCluster = 16'd1; myBest = 16'd8;
    applyStimulus("three", 0);

    fillBackground();
    setCount(16'd0);
    applyStimulus("empty", 0);

    fillBackground();
    setCount(16'd2);
    setNeighbor(0, 16'd9, 16'd4, 16'd3, 16'h5151);
    setNeighbor(1, 16'd10, 16'd4, 16'd3, 16'h6262);
    myCluster = 16'd4; myBest = 16'd3;
    applyStimulus("tie", 0);

    fillBackground();
    setCount(16'd20);
    for (int i = 0; i < 20; i++) setNeighbor(i, 16'(100 + i), 16'd2, 16'(40 - i), 16'(16'h7000 + i));
    myCluster = 16'd2; myBest = 16'd100;
    applyStimulus("saturate", 0);
    applyStimulus("abort", 60);
    applyStimulus("rerun", 0);

    for (int t = 0; t < 10; t++) begin
      fillBackground();
      setCount(16'($urandom_range(0, 72)));
      for (int i = 0; i < 64; i++)
        setNeighbor(i, 16'($urandom), 16'($urandom_range(1, 3)),
                    16'($urandom_range(0, 24)), 16'($urandom));
      myCluster = 16'($urandom_range(1, 3));
      myBest    = 16'($urandom_range(0, 26));
      applyStimulus($sformatf("rand%0d", t), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
